// File: rtl/filt_s2_pkg.sv
// Shared types and constants for the stage-2 filter coefficient loader.
// Contents:
//   WIDTH, NUM_FILT, K, CH, COEF_PER_FILT, NUM_COEF, IDX_W, LAST_IDX
//   coef_t     : one signed Q0.16 coefficient
//   filt_t     : one 3x3x3 filter, [fila][columna][canal]
//   ld_state_t : loader FSM states
package filt_s2_pkg;
    localparam int WIDTH         = 17;
    localparam int NUM_FILT      = 4;
    localparam int K             = 3;
    localparam int CH            = 3;
    localparam int COEF_PER_FILT = 27;
    localparam int NUM_COEF      = 108;
    localparam int IDX_W         = 7;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEF - 1);

    typedef logic signed [WIDTH-1:0] coef_t;
    typedef coef_t [K-1:0][K-1:0][CH-1:0] filt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_COMMIT
    } ld_state_t;
endpackage

// File: rtl/filt_idx_decode.sv
// Combinational decode of the linear stream index into filter coordinates.
//   idx = f*27 + fila*9 + columna*3 + canal
// Ports:
//   idx      in  [6:0] linear coefficient index (0..107)
//   f        out [1:0] filter number (0 -> filtro1 .. 3 -> filtro4)
//   fila     out [1:0] row
//   columna  out [1:0] column
//   canal    out [1:0] channel
module filt_idx_decode
    import filt_s2_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [1:0]       f,
    output logic [1:0]       fila,
    output logic [1:0]       columna,
    output logic [1:0]       canal
);
    logic [IDX_W-1:0] rem_filt;
    logic [IDX_W-1:0] rem_fila;

    always_comb begin
        f        = 2'(idx / 7'd27);
        rem_filt = idx % 7'd27;
        fila     = 2'(rem_filt / 7'd9);
        rem_fila = rem_filt % 7'd9;
        columna  = 2'(rem_fila / 7'd3);
        canal    = 2'(rem_fila % 7'd3);
    end
endmodule

// File: rtl/filtros_s2_loader.sv
// Runtime-writable coefficient store for the stage-2 convolution filters.
// Words arrive on a valid/ready stream, are staged in a shadow bank and are
// copied to the active bank in a single cycle, so filtroN never shows a
// partially loaded set.
// Optional feature: define FILT_CKSUM_EN to require a 109th checksum word
// (sum of the 108 coefficients modulo 2^WIDTH) before committing.
// Handshake: a word transfers on a rising edge where s_valid && s_ready;
// s_ready is low in COMMIT and in any cycle where abort is high.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   s_data/s_valid      coefficient stream in, s_ready back-pressure out
//   abort               drop a partial load and return to IDLE
//   busy                state != IDLE
//   done                one-cycle pulse, new set visible on filtroN
//   err                 one-cycle pulse on checksum mismatch
//   filtro1..filtro4    active bank, [fila][columna][canal]
module filtros_s2_loader
    import filt_s2_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  coef_t s_data,
    input  logic  s_valid,
    output logic  s_ready,
    input  logic  abort,
    output logic  busy,
    output logic  done,
    output logic  err,
    output filt_t filtro1,
    output filt_t filtro2,
    output filt_t filtro3,
    output filt_t filtro4
);
    ld_state_t        state;
    ld_state_t        state_next;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic [1:0]       dec_f;
    logic [1:0]       dec_fila;
    logic [1:0]       dec_col;
    logic [1:0]       dec_can;
    filt_t            shadow [NUM_FILT];
    filt_t            active [NUM_FILT];
    logic             ck_match;

    filt_idx_decode u_dec (
        .idx     (idx),
        .f       (dec_f),
        .fila    (dec_fila),
        .columna (dec_col),
        .canal   (dec_can)
    );

    // abort blocks the handshake in the same cycle so no word slips in
    assign s_ready = (state != ST_COMMIT) && !abort;
    assign accept  = s_valid && s_ready;
    assign busy    = (state != ST_IDLE);

`ifdef FILT_CKSUM_EN
    coef_t cksum;
    logic  err_q;

    assign ck_match = (s_data == cksum);
    assign err      = err_q;

    // First word seeds the sum, which is the same as clearing at load start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cksum <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= accept && (state == ST_CHECK) && !ck_match;
            if (accept && !abort) begin
                if (state == ST_IDLE)
                    cksum <= s_data;
                else if (state == ST_LOAD)
                    cksum <= cksum + s_data;
            end
        end
    end
`else
    assign ck_match = 1'b1;
    assign err      = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept) state_next = ST_LOAD;
            ST_LOAD: begin
                if (accept && idx == LAST_IDX) begin
`ifdef FILT_CKSUM_EN
                    state_next = ST_CHECK;
`else
                    state_next = ST_COMMIT;
`endif
                end
            end
`ifdef FILT_CKSUM_EN
            ST_CHECK:  if (accept) state_next = ck_match ? ST_COMMIT : ST_IDLE;
`endif
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        // a commit in flight always completes
        if (abort && state != ST_COMMIT)
            state_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            done  <= 1'b0;
            for (int i = 0; i < NUM_FILT; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            state <= state_next;
            done  <= (state == ST_COMMIT);
            if (state == ST_COMMIT) begin
                for (int i = 0; i < NUM_FILT; i++)
                    active[i] <= shadow[i];
                idx <= '0;
            end else if (abort) begin
                idx <= '0;
            end else if (accept) begin
                if (state == ST_CHECK) begin
                    // shadow contents are left in place; the next load
                    // overwrites every entry before it can be committed
                    idx <= '0;
                end else begin
                    shadow[dec_f][dec_fila][dec_col][dec_can] <= s_data;
                    idx <= idx + 7'd1;
                end
            end
        end
    end

    assign filtro1 = active[0];
    assign filtro2 = active[1];
    assign filtro3 = active[2];
    assign filtro4 = active[3];
endmodule
